// File: rtl/id_operand_stage_pkg.sv
// Shared constants and types for the ID operand stage: stall bus layout,
// forwarding source indices and the instruction hold FSM encoding.
package id_operand_stage_pkg;

  localparam int unsigned STALL_BUS_W  = 6;
  localparam int unsigned STALL_IF_BIT = 1;
  localparam int unsigned STALL_ID_BIT = 2;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int unsigned FWD_EX  = 0;
  localparam int unsigned FWD_MEM = 1;

  localparam int unsigned INST_W = 32;

  typedef enum logic {
    HOLD_RUN  = 1'b0,
    HOLD_HOLD = 1'b1
  } hold_state_e;

  function automatic logic [4:0] inst_rs(input logic [INST_W-1:0] inst);
    return inst[25:21];
  endfunction

  function automatic logic [4:0] inst_rt(input logic [INST_W-1:0] inst);
    return inst[20:16];
  endfunction

endpackage

// File: rtl/id_operand_stage_if.sv
// Register-file read port plus the WB and late-producer forwarding buses
// seen by the ID operand stage.
interface id_operand_stage_if #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned NUM_FWD = 2
);

  logic [ADDR_W-1:0]         rf_raddr1;
  logic [ADDR_W-1:0]         rf_raddr2;
  logic [DATA_W-1:0]         rf_rdata1;
  logic [DATA_W-1:0]         rf_rdata2;

  logic                      wb_we;
  logic [ADDR_W-1:0]         wb_waddr;
  logic [DATA_W-1:0]         wb_wdata;

  logic [NUM_FWD-1:0]        fwd_we;
  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr;
  logic [NUM_FWD*DATA_W-1:0] fwd_wdata;
  logic [NUM_FWD-1:0]        fwd_rdy;

  modport master (
    input  rf_raddr1, rf_raddr2,
    output rf_rdata1, rf_rdata2,
    output wb_we, wb_waddr, wb_wdata,
    output fwd_we, fwd_waddr, fwd_wdata, fwd_rdy
  );

  modport slave (
    output rf_raddr1, rf_raddr2,
    input  rf_rdata1, rf_rdata2,
    input  wb_we, wb_waddr, wb_wdata,
    input  fwd_we, fwd_waddr, fwd_wdata, fwd_rdy
  );

endinterface

// File: rtl/id_operand_stage_fwd_select.sv
// Per-operand bypass mux: youngest matching forwarding source wins, then WB,
// then the register file. Register 0 always reads zero and never stalls.
module id_operand_stage_fwd_select
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned DATA_W  = 32
) (
  input  logic [ADDR_W-1:0]         addr_i,
  input  logic [NUM_FWD-1:0]        fwd_we_i,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_waddr_i,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_wdata_i,
  input  logic [NUM_FWD-1:0]        fwd_rdy_i,
  input  logic                      wb_we_i,
  input  logic [ADDR_W-1:0]         wb_waddr_i,
  input  logic [DATA_W-1:0]         wb_wdata_i,
  input  logic [DATA_W-1:0]         rf_rdata_i,
  output logic                      hit_o,
  output logic                      rdy_o,
  output logic [DATA_W-1:0]         data_o
);

  always_comb begin
    hit_o  = 1'b0;
    rdy_o  = 1'b1;
    data_o = rf_rdata_i;
    if (wb_we_i && (wb_waddr_i == addr_i)) begin
      data_o = wb_wdata_i;
    end
    // Walk oldest to youngest so a younger match overwrites an older one,
    // including its ready flag, even when the younger one is not ready.
    for (int unsigned i = FWD_EX; i < NUM_FWD; i++) begin
      if (fwd_we_i[NUM_FWD-1-i] &&
          (fwd_waddr_i[(NUM_FWD-1-i)*ADDR_W +: ADDR_W] == addr_i)) begin
        hit_o  = 1'b1;
        rdy_o  = fwd_rdy_i[NUM_FWD-1-i];
        data_o = fwd_wdata_i[(NUM_FWD-1-i)*DATA_W +: DATA_W];
      end
    end
    if (addr_i == '0) begin
      hit_o  = 1'b0;
      rdy_o  = 1'b1;
      data_o = '0;
    end
  end

endmodule

// File: rtl/id_operand_stage.sv
// ID-side operand logic: IF/ID register, instruction hold buffer for the
// synchronous inst SRAM, forwarding network and saturating stall counter.
module id_operand_stage
  import id_operand_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned NUM_FWD = 2,
  parameter int unsigned STALL_W = STALL_BUS_W,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STALL_W-1:0]  stall,
  input  logic                flush,
  input  logic                if_ce,
  input  logic [PC_W-1:0]     if_pc,
  input  logic [INST_W-1:0]   inst_sram_rdata,
  input  logic                use_rs,
  input  logic                use_rt,
  id_operand_stage_if.slave   bus,
  output logic                id_valid,
  output logic [PC_W-1:0]     id_pc,
  output logic [INST_W-1:0]   id_inst,
  output logic [DATA_W-1:0]   rs_data,
  output logic [DATA_W-1:0]   rt_data,
  output logic                stallreq,
  output logic [CNT_W-1:0]    stall_cnt
);

  logic              stall_if;
  logic              stall_id;
  logic              unused_stall;

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  hold_state_e       state_q, state_d;
  logic [INST_W-1:0] hold_inst_q, hold_inst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [ADDR_W-1:0] raddr1, raddr2;
  logic              hit_rs, rdy_rs, hit_rt, rdy_rt;

  assign stall_if     = stall[STALL_IF_BIT];
  assign stall_id     = stall[STALL_ID_BIT];
  assign unused_stall = ^stall;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      pc_d    = '0;
    end else if ((stall_if == STOP) && (stall_id == NO_STOP)) begin
      valid_d = 1'b0;
      pc_d    = '0;
    end else if (stall_if == NO_STOP) begin
      valid_d = if_ce;
      pc_d    = if_pc;
    end
  end

  // The SRAM word is only valid the cycle after fetch, so it is latched on
  // the first ID stall edge and replayed until the stall drops.
  always_comb begin
    state_d     = state_q;
    hold_inst_d = hold_inst_q;
    case (state_q)
      HOLD_RUN: begin
        if (!flush && (stall_id == STOP) && valid_q) begin
          state_d     = HOLD_HOLD;
          hold_inst_d = inst_sram_rdata;
        end
      end
      HOLD_HOLD: begin
        if (flush || (stall_id == NO_STOP)) begin
          state_d     = HOLD_RUN;
          hold_inst_d = '0;
        end
      end
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stallreq && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= 1'b0;
      pc_q        <= '0;
      state_q     <= HOLD_RUN;
      hold_inst_q <= '0;
      cnt_q       <= '0;
    end else begin
      valid_q     <= valid_d;
      pc_q        <= pc_d;
      state_q     <= state_d;
      hold_inst_q <= hold_inst_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    id_inst = '0;
    if (valid_q) begin
      id_inst = (state_q == HOLD_HOLD) ? hold_inst_q : inst_sram_rdata;
    end
  end

  assign raddr1        = ADDR_W'(inst_rs(id_inst));
  assign raddr2        = ADDR_W'(inst_rt(id_inst));
  assign bus.rf_raddr1 = raddr1;
  assign bus.rf_raddr2 = raddr2;

  id_operand_stage_fwd_select #(
    .NUM_FWD (NUM_FWD),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_fwd_rs (
    .addr_i      (raddr1),
    .fwd_we_i    (bus.fwd_we),
    .fwd_waddr_i (bus.fwd_waddr),
    .fwd_wdata_i (bus.fwd_wdata),
    .fwd_rdy_i   (bus.fwd_rdy),
    .wb_we_i     (bus.wb_we),
    .wb_waddr_i  (bus.wb_waddr),
    .wb_wdata_i  (bus.wb_wdata),
    .rf_rdata_i  (bus.rf_rdata1),
    .hit_o       (hit_rs),
    .rdy_o       (rdy_rs),
    .data_o      (rs_data)
  );

  id_operand_stage_fwd_select #(
    .NUM_FWD (NUM_FWD),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) u_fwd_rt (
    .addr_i      (raddr2),
    .fwd_we_i    (bus.fwd_we),
    .fwd_waddr_i (bus.fwd_waddr),
    .fwd_wdata_i (bus.fwd_wdata),
    .fwd_rdy_i   (bus.fwd_rdy),
    .wb_we_i     (bus.wb_we),
    .wb_waddr_i  (bus.wb_waddr),
    .wb_wdata_i  (bus.wb_wdata),
    .rf_rdata_i  (bus.rf_rdata2),
    .hit_o       (hit_rt),
    .rdy_o       (rdy_rt),
    .data_o      (rt_data)
  );

  assign stallreq  = valid_q & ((use_rs & hit_rs & ~rdy_rs) |
                                (use_rt & hit_rt & ~rdy_rt));
  assign id_valid  = valid_q;
  assign id_pc     = pc_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Randomised and directed checks of id_operand_stage against a behavioural
// model; a second instance with a 3-bit counter covers saturation.
module tb_id_operand_stage;
  import id_operand_stage_pkg::*;

  logic        clk;
  logic        rst;
  logic [5:0]  t_stall;
  logic        t_flush, t_if_ce, t_use_rs, t_use_rt;
  logic [31:0] t_if_pc, t_sram;
  logic [31:0] t_rf1, t_rf2;
  logic        t_wb_we;
  logic [4:0]  t_wb_addr;
  logic [31:0] t_wb_data;
  logic        f_we   [2];
  logic [4:0]  f_addr [2];
  logic [31:0] f_data [2];
  logic        f_rdy  [2];

  logic        id_valid, stallreq;
  logic [31:0] id_pc, id_inst, rs_data, rt_data, stall_cnt;
  logic        d2_valid, d2_stallreq;
  logic [31:0] d2_pc, d2_inst, d2_rs, d2_rt;
  logic [2:0]  d2_cnt;

  id_operand_stage_if #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(2)) bus ();
  id_operand_stage_if #(.DATA_W(32), .ADDR_W(5), .NUM_FWD(2)) bus2 ();

  assign bus.rf_rdata1  = t_rf1;
  assign bus.rf_rdata2  = t_rf2;
  assign bus.wb_we      = t_wb_we;
  assign bus.wb_waddr   = t_wb_addr;
  assign bus.wb_wdata   = t_wb_data;
  assign bus.fwd_we     = {f_we[1], f_we[0]};
  assign bus.fwd_waddr  = {f_addr[1], f_addr[0]};
  assign bus.fwd_wdata  = {f_data[1], f_data[0]};
  assign bus.fwd_rdy    = {f_rdy[1], f_rdy[0]};
  assign bus2.rf_rdata1 = t_rf1;
  assign bus2.rf_rdata2 = t_rf2;
  assign bus2.wb_we     = t_wb_we;
  assign bus2.wb_waddr  = t_wb_addr;
  assign bus2.wb_wdata  = t_wb_data;
  assign bus2.fwd_we    = {f_we[1], f_we[0]};
  assign bus2.fwd_waddr = {f_addr[1], f_addr[0]};
  assign bus2.fwd_wdata = {f_data[1], f_data[0]};
  assign bus2.fwd_rdy   = {f_rdy[1], f_rdy[0]};

  id_operand_stage #(
    .DATA_W(32), .ADDR_W(5), .PC_W(32), .NUM_FWD(2), .STALL_W(6), .CNT_W(32)
  ) u_dut (
    .clk(clk), .rst(rst), .stall(t_stall), .flush(t_flush), .if_ce(t_if_ce),
    .if_pc(t_if_pc), .inst_sram_rdata(t_sram), .use_rs(t_use_rs), .use_rt(t_use_rt),
    .bus(bus), .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst),
    .rs_data(rs_data), .rt_data(rt_data), .stallreq(stallreq), .stall_cnt(stall_cnt)
  );

  id_operand_stage #(
    .DATA_W(32), .ADDR_W(5), .PC_W(32), .NUM_FWD(2), .STALL_W(6), .CNT_W(3)
  ) u_dut_sat (
    .clk(clk), .rst(rst), .stall(t_stall), .flush(t_flush), .if_ce(t_if_ce),
    .if_pc(t_if_pc), .inst_sram_rdata(t_sram), .use_rs(t_use_rs), .use_rt(t_use_rt),
    .bus(bus2), .id_valid(d2_valid), .id_pc(d2_pc), .id_inst(d2_inst),
    .rs_data(d2_rs), .rt_data(d2_rt), .stallreq(d2_stallreq), .stall_cnt(d2_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // reference model state
  bit              m_valid;
  logic [31:0]     m_pc;
  bit              m_hold;
  logic [31:0]     m_hold_inst;
  longint unsigned m_cnt;

  logic [31:0]     e_inst, e_rs, e_rt;
  bit              e_stallreq;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic void model_reset();
    m_valid     = 1'b0;
    m_pc        = '0;
    m_hold      = 1'b0;
    m_hold_inst = '0;
    m_cnt       = 0;
  endfunction

  function automatic void resolve(input logic [4:0] a, input logic [31:0] rf,
                                  output logic [31:0] d, output bit pend);
    pend = 1'b0;
    d    = rf;
    if (a == 5'd0) begin
      d = '0;
      return;
    end
    for (int i = 0; i < 2; i++) begin
      if (f_we[i] && f_addr[i] == a) begin
        d    = f_data[i];
        pend = !f_rdy[i];
        return;
      end
    end
    if (t_wb_we && t_wb_addr == a) d = t_wb_data;
  endfunction

  function automatic void compute();
    bit p_rs, p_rt;
    e_inst = !m_valid ? 32'h0 : (m_hold ? m_hold_inst : t_sram);
    resolve(e_inst[25:21], t_rf1, e_rs, p_rs);
    resolve(e_inst[20:16], t_rf2, e_rt, p_rt);
    e_stallreq = m_valid && ((t_use_rs && p_rs) || (t_use_rt && p_rt));
  endfunction

  task automatic settle();
    #1;
    compute();
    check_eq("id_valid", id_valid, m_valid);
    check_eq("id_pc", id_pc, m_pc);
    check_eq("id_inst", id_inst, e_inst);
    check_eq("raddr1", bus.rf_raddr1, e_inst[25:21]);
    check_eq("raddr2", bus.rf_raddr2, e_inst[20:16]);
    check_eq("rs_data", rs_data, e_rs);
    check_eq("rt_data", rt_data, e_rt);
    check_eq("stallreq", stallreq, e_stallreq);
    check_eq("stall_cnt", stall_cnt, (m_cnt > 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : m_cnt);
    check_eq("stall_cnt3", d2_cnt, (m_cnt > 7) ? 64'd7 : m_cnt);
  endtask

  task automatic tick();
    bit s1, s2;
    compute();
    s1 = t_stall[1];
    s2 = t_stall[2];
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (e_stallreq) m_cnt++;
      if (t_flush) begin
        m_hold = 1'b0; m_hold_inst = '0;
      end else if (m_hold) begin
        if (!s2) begin m_hold = 1'b0; m_hold_inst = '0; end
      end else if (s2 && m_valid) begin
        m_hold = 1'b1; m_hold_inst = t_sram;
      end
      if (t_flush || (s1 && !s2)) begin
        m_valid = 1'b0; m_pc = '0;
      end else if (!s1) begin
        m_valid = t_if_ce; m_pc = t_if_pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    t_stall = '0; t_flush = 1'b0; t_if_ce = 1'b1; t_if_pc = 32'hBFC0_0000;
    t_use_rs = 1'b0; t_use_rt = 1'b0; t_sram = '0;
    t_rf1 = 32'hAAAA_0001; t_rf2 = 32'hBBBB_0002;
    t_wb_we = 1'b0; t_wb_addr = '0; t_wb_data = '0;
    for (int i = 0; i < 2; i++) begin
      f_we[i] = 1'b0; f_addr[i] = '0; f_data[i] = '0; f_rdy[i] = 1'b1;
    end
  endtask

  task automatic randomize_inputs();
    t_stall  = 6'($urandom);
    t_stall[1] = ($urandom_range(0, 3) == 0);
    t_stall[2] = ($urandom_range(0, 3) == 0);
    t_flush  = ($urandom_range(0, 19) == 0);
    t_if_ce  = ($urandom_range(0, 9) != 0);
    t_if_pc  = $urandom;
    t_sram   = $urandom;
    t_sram[25:21] = 5'($urandom_range(0, 3));
    t_sram[20:16] = 5'($urandom_range(0, 3));
    t_use_rs = 1'($urandom);
    t_use_rt = 1'($urandom);
    t_rf1    = $urandom;
    t_rf2    = $urandom;
    t_wb_we  = 1'($urandom);
    t_wb_addr = 5'($urandom_range(0, 3));
    t_wb_data = $urandom;
    for (int i = 0; i < 2; i++) begin
      f_we[i]   = 1'($urandom);
      f_addr[i] = 5'($urandom_range(0, 3));
      f_data[i] = $urandom;
      f_rdy[i]  = ($urandom_range(0, 9) < 7);
    end
  endtask

  initial begin
    longint unsigned c0;
    rst = 1'b1;
    idle();
    model_reset();
    @(negedge clk);
    settle();
    check_eq("rst_valid", id_valid, 1'b0);
    check_eq("rst_cnt", stall_cnt, 32'd0);
    tick();
    rst = 1'b0;

    // normal flow
    idle();
    settle(); tick();
    t_sram = 32'h8C09_0000; t_if_pc = 32'hBFC0_0004;
    settle();
    check_eq("flow_pc", id_pc, 32'hBFC0_0000);
    check_eq("flow_valid", id_valid, 1'b1);
    check_eq("flow_inst", id_inst, 32'h8C09_0000);
    tick();

    // forwarding priority, rs = r8
    t_sram = 32'h0100_0000; t_use_rs = 1'b1;
    f_we[FWD_EX] = 1'b1;  f_addr[FWD_EX] = 5'd8;  f_data[FWD_EX] = 32'h11;
    f_we[FWD_MEM] = 1'b1; f_addr[FWD_MEM] = 5'd8; f_data[FWD_MEM] = 32'h22;
    t_wb_we = 1'b1; t_wb_addr = 5'd8; t_wb_data = 32'h33;
    settle(); check_eq("prio_ex", rs_data, 32'h11); tick();
    f_we[FWD_EX] = 1'b0;
    settle(); check_eq("prio_mem", rs_data, 32'h22); tick();
    f_we[FWD_MEM] = 1'b0;
    settle(); check_eq("prio_wb", rs_data, 32'h33); tick();
    t_sram = 32'h0000_0000;
    f_we[FWD_EX] = 1'b1; f_addr[FWD_EX] = 5'd0;
    f_we[FWD_MEM] = 1'b1; f_addr[FWD_MEM] = 5'd0; f_rdy[FWD_EX] = 1'b0;
    t_wb_addr = 5'd0;
    settle();
    check_eq("prio_r0", rs_data, 32'h0);
    check_eq("r0_nostall", stallreq, 1'b0);
    tick();
    // younger not-ready source blocks an older ready one
    t_sram = 32'h0100_0000;
    f_addr[FWD_EX] = 5'd8; f_rdy[FWD_EX] = 1'b0;
    f_addr[FWD_MEM] = 5'd8; f_rdy[FWD_MEM] = 1'b1;
    settle(); check_eq("young_block", stallreq, 1'b1); tick();

    // late producer on rt
    idle();
    t_sram = 32'h8C09_0000; t_use_rt = 1'b1;
    f_we[FWD_EX] = 1'b1; f_addr[FWD_EX] = 5'd9; f_rdy[FWD_EX] = 1'b0;
    c0 = m_cnt;
    settle(); check_eq("late_stallreq", stallreq, 1'b1); tick();
    settle(); check_eq("late_cnt", stall_cnt, c0 + 1);
    t_use_rt = 1'b0;
    settle(); check_eq("late_nouse", stallreq, 1'b0); tick();

    // multi-cycle hold
    idle();
    t_sram = 32'h8C09_0000; t_stall = 6'b000110;
    settle(); tick();
    t_sram = 32'hDEAD_BEEF;
    repeat (2) begin settle(); check_eq("hold_inst", id_inst, 32'h8C09_0000); tick(); end
    t_stall = '0; t_if_pc = 32'hBFC0_0010;
    settle(); check_eq("hold_last", id_inst, 32'h8C09_0000); tick();
    t_sram = 32'h1234_5678;
    settle();
    check_eq("release_inst", id_inst, 32'h1234_5678);
    check_eq("release_pc", id_pc, 32'hBFC0_0010);
    tick();

    // flush during hold
    t_sram = 32'h8C09_0000; t_stall = 6'b000110;
    settle(); tick();
    t_flush = 1'b1; t_sram = 32'hDEAD_BEEF;
    settle(); tick();
    t_flush = 1'b0; t_stall = '0;
    settle();
    check_eq("flush_valid", id_valid, 1'b0);
    check_eq("flush_inst", id_inst, 32'h0);
    tick();
    t_sram = 32'h0BAD_F00D;
    settle(); check_eq("flush_run", id_inst, 32'h0BAD_F00D); tick();

    // randomised traffic
    for (int n = 0; n < 400; n++) begin
      randomize_inputs();
      settle();
      tick();
    end

    // asynchronous reset while holding
    idle();
    t_sram = 32'h8C09_0000;
    settle(); tick();
    t_stall = 6'b000110;
    settle(); tick();
    t_sram = 32'hDEAD_BEEF;
    settle();
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", id_valid, 1'b0);
    check_eq("arst_pc", id_pc, 32'h0);
    check_eq("arst_inst", id_inst, 32'h0);
    check_eq("arst_cnt", stall_cnt, 32'h0);
    check_eq("arst_cnt3", d2_cnt, 3'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle();
    settle(); tick();
    t_sram = 32'h2222_0000;
    settle(); check_eq("arst_run", id_inst, 32'h2222_0000); tick();

    // counter saturation
    t_sram = 32'h8C09_0000; t_use_rt = 1'b1;
    f_we[FWD_EX] = 1'b1; f_addr[FWD_EX] = 5'd9; f_rdy[FWD_EX] = 1'b0;
    repeat (9) begin settle(); tick(); end
    settle();
    check_eq("sat_cnt3", d2_cnt, 3'd7);
    check_eq("sat_cnt32", stall_cnt, 32'd9);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
